// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AXI-to-APB bridge.
// Holds the APB master state encoding, the bit layout of the command word
// {write, addr, wdata, strb} and of the response word {rdata, slverr, timeout}.
// The AXI-side packer/unpacker uses the same layout, so the offsets are
// provided both as functions of the bus widths and as localparams for the
// default 32/32 configuration.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } apb_state_e;

  localparam int unsigned APB_ADDR_WIDTH = 32;
  localparam int unsigned APB_DATA_WIDTH = 32;

  // Command word, LSB first: strb, wdata, addr, write.
  function automatic int unsigned cmd_strb_lsb();
    return 0;
  endfunction

  function automatic int unsigned cmd_wdata_lsb(int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned cmd_addr_lsb(int unsigned dw);
    return dw + dw / 8;
  endfunction

  function automatic int unsigned cmd_write_bit(int unsigned aw, int unsigned dw);
    return aw + dw + dw / 8;
  endfunction

  localparam int unsigned CMD_STRB_LSB  = cmd_strb_lsb();
  localparam int unsigned CMD_WDATA_LSB = cmd_wdata_lsb(APB_DATA_WIDTH);
  localparam int unsigned CMD_ADDR_LSB  = cmd_addr_lsb(APB_DATA_WIDTH);
  localparam int unsigned CMD_WRITE_BIT = cmd_write_bit(APB_ADDR_WIDTH, APB_DATA_WIDTH);

  // Response word, LSB first: timeout, slverr, rdata.
  localparam int unsigned RSP_TIMEOUT_BIT = 0;
  localparam int unsigned RSP_SLVERR_BIT  = 1;
  localparam int unsigned RSP_RDATA_LSB   = 2;

endpackage

// File: rtl/apb_master_fsm.sv
// APB4 master for the AXI-to-APB bridge (APB clock domain).
// Pops one command from the show-ahead command FIFO, runs it as a single APB
// transfer (SETUP then ACCESS with PREADY wait states and a bounded-wait
// timeout) and pushes exactly one response word into the response FIFO.
//
// Ports:
//   clk, rst            APB clock, asynchronous active-high reset
//   cmd_empty/cmd_data  command FIFO head {write, addr, wdata, strb}
//   cmd_rd              command FIFO pop strobe
//   rsp_full            response FIFO full
//   rsp_wr/rsp_data     response push strobe and word {rdata, slverr, timeout}
//   psel..pstrb         APB request outputs
//   pready/prdata/pslverr  APB completion inputs
//   busy                high whenever a command is in flight
module apb_master_fsm
  import apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CMD_WIDTH      = 1 + ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH / 8,
  parameter int unsigned RSP_WIDTH      = DATA_WIDTH + 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_empty,
  input  logic [CMD_WIDTH-1:0]    cmd_data,
  output logic                    cmd_rd,
  input  logic                    rsp_full,
  output logic                    rsp_wr,
  output logic [RSP_WIDTH-1:0]    rsp_data,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr,
  output logic                    busy
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  localparam int unsigned STRB_POS  = cmd_strb_lsb();
  localparam int unsigned WDATA_POS = cmd_wdata_lsb(DATA_WIDTH);
  localparam int unsigned ADDR_POS  = cmd_addr_lsb(DATA_WIDTH);
  localparam int unsigned WRITE_POS = cmd_write_bit(ADDR_WIDTH, DATA_WIDTH);

  // Command head fields
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_strb;

  assign cmd_write = cmd_data[WRITE_POS];
  assign cmd_addr  = cmd_data[ADDR_POS +: ADDR_WIDTH];
  assign cmd_wdata = cmd_data[WDATA_POS +: DATA_WIDTH];
  assign cmd_strb  = cmd_data[STRB_POS +: STRB_WIDTH];

  apb_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pop;
  logic                 rsp_load;
  logic [RSP_WIDTH-1:0] rsp_word_d;

  logic                  psel_q, penable_q, rsp_wr_q, busy_q, pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_WIDTH-1:0] pstrb_q;
  logic [RSP_WIDTH-1:0]  rsp_data_q;

  // Next-state, timeout counter and response word.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pop        = 1'b0;
    rsp_load   = 1'b0;
    rsp_word_d = '0;

    unique case (state_q)
      StIdle: begin
        // rsp_full is only consulted here: this block is the sole writer of
        // the response FIFO, so a free slot at pop time stays free until RESP.
        // cmd_data is only looked at once cmd_empty is low.
        if (!rst && !cmd_empty && !rsp_full) begin
          pop     = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        // pready on the last allowed cycle takes priority over the abort.
        if (pready) begin
          rsp_load = 1'b1;
          state_d  = StResp;
          if (!pwrite_q) begin
            rsp_word_d[RSP_RDATA_LSB +: DATA_WIDTH] = prdata;
          end
          rsp_word_d[RSP_SLVERR_BIT]  = pslverr;
          rsp_word_d[RSP_TIMEOUT_BIT] = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          rsp_load = 1'b1;
          state_d  = StResp;
          rsp_word_d[RSP_SLVERR_BIT]  = 1'b1;
          rsp_word_d[RSP_TIMEOUT_BIT] = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      StResp: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // The pop strobe must coincide with the IDLE cycle in which the head is
  // sampled, so it is decoded from the registered state rather than delayed.
  assign cmd_rd = pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      rsp_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      psel_q    <= (state_d == StSetup) || (state_d == StAccess);
      penable_q <= (state_d == StAccess);
      rsp_wr_q  <= (state_d == StResp);
      busy_q    <= (state_d != StIdle);
      // Request fields hold from SETUP to the end of ACCESS and beyond.
      if (pop) begin
        pwrite_q <= cmd_write;
        paddr_q  <= cmd_addr;
        pwdata_q <= cmd_write ? cmd_wdata : '0;
        pstrb_q  <= cmd_write ? cmd_strb : '0;
      end
      if (rsp_load) begin
        rsp_data_q <= rsp_word_d;
      end
    end
  end

  assign psel     = psel_q;
  assign penable  = penable_q;
  assign rsp_wr   = rsp_wr_q;
  assign busy     = busy_q;
  assign pwrite   = pwrite_q;
  assign paddr    = paddr_q;
  assign pwdata   = pwdata_q;
  assign pstrb    = pstrb_q;
  assign rsp_data = rsp_data_q;

  // Protocol sanity.
  a_penable_needs_psel : assert property (@(posedge clk) disable iff (rst) penable |-> psel);
  a_rsp_never_full     : assert property (@(posedge clk) disable iff (rst) rsp_wr |-> !rsp_full);

endmodule
